// File: rtl/data_ram_responder.sv
// Data-side load/store RAM responder; DATA_RAM_RANGE_CHECK_EN flags out-of-range addresses instead of wrapping.
// Latency 1+WAIT_CYCLES from accept to resp_valid; holds the response until resp_ready, 1/cycle streaming when WAIT_CYCLES=0.
module data_ram_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [3:0]  req_wen,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [3:0]            r_cnt;
    logic [31:0]           r_req_addr;
    logic [3:0]            r_req_wen;
    logic [31:0]           r_req_wdata;
    logic [31:0]           r_rdata;
    logic                  r_err;
    logic [31:0]           r_mem [DEPTH];

    logic                  w_ready;
    logic                  w_accept;
    logic                  w_commit;
    logic                  w_cmt_from_reg;
    logic [31:0]           w_cmt_addr;
    logic [3:0]            w_cmt_wen;
    logic [31:0]           w_cmt_wdata;
    logic [ADDR_WIDTH-1:0] w_idx;
    logic                  w_oor;

    always_comb begin
        w_state_nxt    = r_state;
        w_ready        = 1'b0;
        w_commit       = 1'b0;
        w_cmt_from_reg = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ready = 1'b1;
                if (req_valid) begin
                    if (WAIT_CYCLES == 0) begin
                        w_commit    = 1'b1;
                        w_state_nxt = S_RESP;
                    end else begin
                        w_state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd1) begin
                    w_commit       = 1'b1;
                    w_cmt_from_reg = 1'b1;
                    w_state_nxt    = S_RESP;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    // Zero-wait builds refill the response slot in the same cycle it drains.
                    w_ready = (WAIT_CYCLES == 0);
                    if ((WAIT_CYCLES == 0) && req_valid) begin
                        w_commit = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign req_ready   = w_ready & resetn;
    assign w_accept    = req_valid & req_ready;
    assign w_cmt_addr  = w_cmt_from_reg ? r_req_addr  : req_addr;
    assign w_cmt_wen   = w_cmt_from_reg ? r_req_wen   : req_wen;
    assign w_cmt_wdata = w_cmt_from_reg ? r_req_wdata : req_wdata;
    assign w_idx       = w_cmt_addr[ADDR_WIDTH-1:0];

`ifdef DATA_RAM_RANGE_CHECK_EN
    assign w_oor = |w_cmt_addr[31:ADDR_WIDTH];
`else
    logic w_unused;
    assign w_oor    = 1'b0;
    assign w_unused = &{1'b0, w_cmt_addr[31:ADDR_WIDTH]};
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_req_addr  <= 32'd0;
            r_req_wen   <= 4'd0;
            r_req_wdata <= 32'd0;
            r_rdata     <= 32'd0;
            r_err       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_req_addr  <= req_addr;
                r_req_wen   <= req_wen;
                r_req_wdata <= req_wdata;
                r_cnt       <= 4'(WAIT_CYCLES);
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_commit) begin
                r_rdata <= w_oor ? 32'd0 : r_mem[w_idx];
                r_err   <= w_oor;
            end
        end
    end

    // RAM is never reset; resetn gates the write so a reset edge cannot commit a store.
    always_ff @(posedge clk) begin
        if (resetn && w_commit && !w_oor) begin
            for (int b = 0; b < 4; b++) begin
                if (w_cmt_wen[b]) r_mem[w_idx][8*b +: 8] <= w_cmt_wdata[8*b +: 8];
            end
        end
    end

    assign resp_valid = (r_state == S_RESP);
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;
endmodule
